asc2ps2_tx: RTL and testbench

Converts an ASCII character into PS/2 Set-2 scan codes and serially emits the complete keystroke on a PS/2 device-side clock/data pair. Each keystroke is the make code, then the break prefix `0xF0`, then the make code again. The block is the transmitting counterpart of the keyboard receive path (`ps2` receiver → `key2asc`). It drives the receiver in loop-back tests and emulates typed input for the `wordinput` design. It accepts one character per valid/ready handshake.

---
 rtl/asc2ps2_tx.sv | 176 +++++++++++++++++
 tb/tb_asc2ps2_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/asc2ps2_tx.sv
// ASCII to PS/2 Set-2 keystroke transmitter: make code, 0xF0, make code,
// each sent as an 11-bit device-to-host frame on a divided PS/2 clock.
module asc2ps2_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_ascii,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       unmapped
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    code_q, code_d;
    logic          clk_q, clk_d, data_q, data_d;
    logic          ready_q, ready_d, busy_q, busy_d, unm_q, unm_d;

    logic [8:0]  map;
    logic [7:0]  cur_byte;
    logic [10:0] frame;
    logic [3:0]  bit_nxt;

    // Returns {mapped, scan_code}; lowercase folds onto uppercase first.
    function automatic logic [8:0] map_code(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            8'h41: map_code = {1'b1, 8'h1C};  8'h42: map_code = {1'b1, 8'h32};
            8'h43: map_code = {1'b1, 8'h21};  8'h44: map_code = {1'b1, 8'h23};
            8'h45: map_code = {1'b1, 8'h24};  8'h46: map_code = {1'b1, 8'h2B};
            8'h47: map_code = {1'b1, 8'h34};  8'h48: map_code = {1'b1, 8'h33};
            8'h49: map_code = {1'b1, 8'h43};  8'h4A: map_code = {1'b1, 8'h3B};
            8'h4B: map_code = {1'b1, 8'h42};  8'h4C: map_code = {1'b1, 8'h4B};
            8'h4D: map_code = {1'b1, 8'h3A};  8'h4E: map_code = {1'b1, 8'h31};
            8'h4F: map_code = {1'b1, 8'h44};  8'h50: map_code = {1'b1, 8'h4D};
            8'h51: map_code = {1'b1, 8'h15};  8'h52: map_code = {1'b1, 8'h2D};
            8'h53: map_code = {1'b1, 8'h1B};  8'h54: map_code = {1'b1, 8'h2C};
            8'h55: map_code = {1'b1, 8'h3C};  8'h56: map_code = {1'b1, 8'h2A};
            8'h57: map_code = {1'b1, 8'h1D};  8'h58: map_code = {1'b1, 8'h22};
            8'h59: map_code = {1'b1, 8'h35};  8'h5A: map_code = {1'b1, 8'h1A};
            8'h30: map_code = {1'b1, 8'h45};  8'h31: map_code = {1'b1, 8'h16};
            8'h32: map_code = {1'b1, 8'h1E};  8'h33: map_code = {1'b1, 8'h26};
            8'h34: map_code = {1'b1, 8'h25};  8'h35: map_code = {1'b1, 8'h2E};
            8'h36: map_code = {1'b1, 8'h36};  8'h37: map_code = {1'b1, 8'h3D};
            8'h38: map_code = {1'b1, 8'h3E};  8'h39: map_code = {1'b1, 8'h46};
            8'h20: map_code = {1'b1, 8'h29};  8'h08: map_code = {1'b1, 8'h66};
            8'h09: map_code = {1'b1, 8'h0D};  8'h0D: map_code = {1'b1, 8'h5A};
            8'h1B: map_code = {1'b1, 8'h76};
            default: map_code = 9'h000;
        endcase
    endfunction

    assign map      = map_code(in_ascii);
    assign cur_byte = (byte_q == 2'd1) ? 8'hF0 : code_q;
    assign frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};
    assign bit_nxt  = bit_q + 4'd1;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        code_d  = code_q;
        clk_d   = clk_q;
        data_d  = data_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        unm_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (map[8]) begin
                        state_d = S_SHIFT;
                        code_d  = map[7:0];
                        byte_d  = 2'd0;
                        bit_d   = 4'd0;
                        half_d  = '0;
                        clk_d   = 1'b1;
                        data_d  = 1'b0;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        unm_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (half_q == HW'(CLK_DIV - 1)) begin
                    half_d = '0;
                    clk_d  = ~clk_q;
                    // End of the low half closes the bit; data moves while clock is high.
                    if (!clk_q) begin
                        if (bit_q == 4'd10) begin
                            state_d = S_GAP;
                            bit_d   = 4'd0;
                            gap_d   = '0;
                            data_d  = 1'b1;
                        end else begin
                            bit_d  = bit_nxt;
                            data_d = frame[bit_nxt];
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    gap_d = '0;
                    if (byte_q == 2'd2) begin
                        state_d = S_IDLE;
                        byte_d  = 2'd0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                        byte_d  = byte_q + 2'd1;
                        half_d  = '0;
                        data_d  = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            half_q  <= '0;
            gap_q   <= '0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            code_q  <= 8'h00;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            unm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            code_q  <= code_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            unm_q   <= unm_d;
        end
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign unmapped = unm_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;
endmodule

// File: tb/tb_asc2ps2_tx.sv
// Scoreboard bench for asc2ps2_tx: stimulus queues expected bytes, a monitor
// decodes frames on ps2_clk falling edges and compares.
module tb_asc2ps2_tx;
    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_ascii = 8'h00;
    logic       in_ready, ps2_clk, ps2_data, busy, unmapped;

    asc2ps2_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ascii(in_ascii), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .busy(busy), .unmapped(unmapped)
    );

    always #5 clk = ~clk;

    int          nvec = 0, nerr = 0;
    logic [7:0]  exq[$];
    int          fall_cnt = 0, unm_cnt = 0, nbits = 0;
    logic [10:0] got;
    logic        prev_clk = 1'b1, prev_data = 1'b1;

    logic [7:0] tc[14] = '{8'h4B, 8'h4D, 8'h50, 8'h57, 8'h58, 8'h59, 8'h35,
                           8'h37, 8'h08, 8'h09, 8'h0D, 8'h1B, 8'h7A, 8'h31};
    logic [7:0] tk[14] = '{8'h42, 8'h3A, 8'h4D, 8'h1D, 8'h22, 8'h35, 8'h2E,
                           8'h3D, 8'h66, 8'h0D, 8'h5A, 8'h76, 8'h1A, 8'h16};
    logic [7:0] un[7]  = '{8'h7E, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h2F, 8'h3A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each rising clk edge.
    initial forever begin
        logic [7:0] e;
        @(posedge clk); #1;
        if (rst) begin
            nbits = 0; prev_clk = 1'b1; prev_data = 1'b1;
        end else begin
            if (unmapped) unm_cnt++;
            if (!prev_clk && !ps2_clk) chk("data_stable_low", ps2_data, prev_data);
            if (prev_clk && !ps2_clk) begin
                fall_cnt++;
                got[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    if (exq.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL frame: unexpected frame %03h", got);
                    end else begin
                        e = exq.pop_front();
                        chk("frame", got, {1'b1, ~^e, e, 1'b0});
                    end
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    // Returns at the negedge just before the accepting rising edge.
    task automatic handshake(input logic [7:0] c, output bit ok);
        int n = 0;
        @(negedge clk); in_valid = 1'b1; in_ascii = c;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        ok = in_ready;
        if (!ok) begin nvec++; nerr++; $display("FAIL handshake_timeout: char %02h", c); end
    endtask

    task automatic push_key(input logic [7:0] k);
        exq.push_back(k); exq.push_back(8'hF0); exq.push_back(k);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !in_ready) && n < 2000) begin @(negedge clk); n++; end
        chk("idle_reached", {busy, in_ready}, 2'b01);
        chk("queue_drained", exq.size(), 0);
    endtask

    task automatic key(input logic [7:0] c, input logic [7:0] k);
        bit ok;
        handshake(c, ok);
        if (ok) push_key(k);
        @(negedge clk); in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic count_low(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 1000) begin cnt++; @(negedge clk); end
    endtask

    task automatic unmapped_key(input logic [7:0] c);
        int u0, f0, bad;
        bit ok;
        u0 = unm_cnt; f0 = fall_cnt; bad = 0;
        handshake(c, ok);
        @(negedge clk); in_valid = 1'b0;
        repeat (20) begin
            if (!in_ready || busy || !ps2_clk || !ps2_data) bad++;
            @(negedge clk);
        end
        chk("unmapped_pulses", unm_cnt - u0, 1);
        chk("unmapped_no_falls", fall_cnt - f0, 0);
        chk("unmapped_idle_lines", bad, 0);
    endtask

    initial begin
        bit ok;
        int cnt, n;
        // Reset held for three cycles, then idle observation.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("reset_idle", {ps2_clk, ps2_data, in_ready, busy, unmapped}, 5'b11100);
        end

        // 'A' with latency and keystroke-length checks.
        handshake(8'h41, ok);
        push_key(8'h1C);
        @(negedge clk); in_valid = 1'b0;
        chk("start_latency", {ps2_clk, ps2_data, busy, in_ready}, 4'b1010);
        count_low(cnt);
        chk("ready_low_cycles", cnt, 3 * (22 * CLK_DIV + GAP));
        wait_idle();

        key(8'h61, 8'h1C);
        key(8'h20, 8'h29);
        key(8'h30, 8'h45);
        for (int i = 0; i < 14; i++) key(tc[i], tk[i]);

        for (int i = 0; i < 7; i++) unmapped_key(un[i]);

        // Back-to-back with in_valid held.
        handshake(8'h42, ok);
        push_key(8'h32);
        @(negedge clk); in_ascii = 8'h43;
        chk("b2b_ready_dropped", in_ready, 1'b0);
        push_key(8'h21);
        count_low(cnt);
        chk("b2b_first_low", cnt, 3 * (22 * CLK_DIV + GAP));
        @(negedge clk);
        chk("b2b_no_idle", {in_ready, busy}, 2'b01);
        in_valid = 1'b0;
        wait_idle();

        // Reset during bit 4 of frame 2.
        handshake(8'h51, ok);
        push_key(8'h15);
        @(negedge clk); in_valid = 1'b0;
        n = fall_cnt + 15;
        cnt = 0;
        while (fall_cnt < n && cnt < 1000) begin @(negedge clk); cnt++; end
        chk("reached_frame2_bit4", fall_cnt >= n, 1'b1);
        repeat (CLK_DIV + 1) @(negedge clk);
        rst = 1'b1; exq.delete();
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_frame", {ps2_clk, ps2_data, in_ready, busy, unmapped}, 5'b11100);
        key(8'h5A, 8'h1A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end
endmodule
